// File: rtl/rtc_disp_pkg.sv
// Shared constants for the RTC front-panel display controller: mode encoding,
// blink masks and mode-sequencing helpers.
package rtc_disp_pkg;

  localparam logic [2:0] SHOW_HM  = 3'd0;
  localparam logic [2:0] SHOW_MS  = 3'd1;
  localparam logic [2:0] SHOW_SW  = 3'd2;
  localparam logic [2:0] SET_HOUR = 3'd3;
  localparam logic [2:0] SET_MIN  = 3'd4;

  localparam logic [3:0] BLANK_LEFT  = 4'b1100;
  localparam logic [3:0] BLANK_RIGHT = 4'b0011;

  function automatic logic [2:0] next_mode(input logic [2:0] m);
    case (m)
      SHOW_HM:  return SHOW_MS;
      SHOW_MS:  return SHOW_SW;
      SHOW_SW:  return SET_HOUR;
      SET_HOUR: return SET_MIN;
      default:  return SHOW_HM;
    endcase
  endfunction

  function automatic logic is_set(input logic [2:0] m);
    return (m == SET_HOUR) || (m == SET_MIN);
  endfunction

endpackage

// File: rtl/rtc_display_ctrl_if.sv
// Front-panel bus: buttons and time values in, display and increment strobes out.
// The slave modport is the controller side.
interface rtc_display_ctrl_if;
  logic        btn_mode;
  logic        btn_inc;
  logic [5:0]  sec;
  logic [5:0]  min;
  logic [4:0]  hour;
  logic [6:0]  sw_sec;
  logic [6:0]  sw_min;
  logic        scan_tick;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        inc_hour;
  logic        inc_min;
  logic [2:0]  mode;

  modport master (
    output btn_mode, btn_inc, sec, min, hour, sw_sec, sw_min,
    input  scan_tick, digits, blank, inc_hour, inc_min, mode
  );

  modport slave (
    input  btn_mode, btn_inc, sec, min, hour, sw_sec, sw_min,
    output scan_tick, digits, blank, inc_hour, inc_min, mode
  );
endinterface

// File: rtl/bin_to_bcd2.sv
// Two-digit binary to BCD converter; values above 99 saturate to 99.
module bin_to_bcd2 (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  always_comb begin
    if (bin > 7'd99) begin
      tens = 4'd9;
      ones = 4'd9;
    end else begin
      tens = 4'(bin / 7'd10);
      ones = 4'(bin % 7'd10);
    end
  end

endmodule

// File: rtl/rtc_display_ctrl.sv
// RTC front-panel mode FSM, scan strobe, BCD digit selection and set-mode blink.
// Optional set-mode inactivity timeout enabled by RTC_DISP_SET_TIMEOUT_EN.
module rtc_display_ctrl
  import rtc_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLINK_TICKS    = 250,
  parameter int unsigned TIMEOUT_BLINKS = 20
) (
  input  logic                clk,
  input  logic                reset,
  rtc_display_ctrl_if.slave   bus
);

  localparam int unsigned SCW = $clog2(SCAN_DIV);
  localparam int unsigned BCW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [SCW-1:0] scan_cnt_q;
  logic [BCW-1:0] blink_q, blink_d;
  logic           phase_q, phase_d;
  logic [2:0]     mode_q, mode_d;
  logic           scan_tick_q, inc_hour_q, inc_min_q;
  logic [15:0]    digits_q;
  logic [3:0]     blank_q;
  logic           scan_tick_d, inc_hour_d, inc_min_d;
  logic [15:0]    digits_d;
  logic [3:0]     blank_d;

  logic scan_wrap, blink_wrap, inc_accept, set_entry, timeout;
  logic [6:0] left_bin, right_bin;
  logic [3:0] l_tens, l_ones, r_tens, r_ones;

  assign scan_wrap  = (scan_cnt_q == SCW'(SCAN_DIV - 1));
  assign blink_wrap = scan_wrap && (blink_q == BCW'(BLINK_TICKS - 1));
  assign inc_accept = bus.btn_inc && !bus.btn_mode && is_set(mode_q);
  assign set_entry  = is_set(mode_d) && (mode_d != mode_q);

`ifdef RTC_DISP_SET_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_BLINKS + 1);
  logic [IW-1:0] idle_q, idle_d;

  assign timeout = is_set(mode_q) && (idle_q >= IW'(TIMEOUT_BLINKS));

  always_comb begin
    idle_d = idle_q;
    if (bus.btn_mode || bus.btn_inc || (mode_d != mode_q)) begin
      idle_d = '0;
    end else if (is_set(mode_q) && blink_wrap) begin
      idle_d = idle_q + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Scan divider runs free regardless of mode or buttons.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          scan_cnt_q <= '0;
    else if (scan_wrap) scan_cnt_q <= '0;
    else                scan_cnt_q <= scan_cnt_q + SCW'(1);
  end

  // State register, including the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= SHOW_HM;
      blink_q     <= '0;
      phase_q     <= 1'b0;
      scan_tick_q <= 1'b0;
      digits_q    <= 16'h0000;
      blank_q     <= 4'b0000;
      inc_hour_q  <= 1'b0;
      inc_min_q   <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
      scan_tick_q <= scan_tick_d;
      digits_q    <= digits_d;
      blank_q     <= blank_d;
      inc_hour_q  <= inc_hour_d;
      inc_min_q   <= inc_min_d;
    end
  end

  // Next state: a button press wins over the inactivity timeout.
  always_comb begin
    mode_d  = mode_q;
    blink_d = blink_q;
    phase_d = phase_q;
    if (bus.btn_mode) begin
      mode_d = next_mode(mode_q);
    end else if (timeout) begin
      mode_d = SHOW_HM;
    end
    if (set_entry || inc_accept) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (blink_wrap) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else if (scan_wrap) begin
      blink_d = blink_q + BCW'(1);
    end
  end

  // Outputs.
  always_comb begin
    scan_tick_d = scan_wrap;
    inc_hour_d  = inc_accept && (mode_q == SET_HOUR);
    inc_min_d   = inc_accept && (mode_q == SET_MIN);
    case (mode_q)
      SHOW_MS: begin
        left_bin  = {1'b0, bus.min};
        right_bin = {1'b0, bus.sec};
      end
      SHOW_SW: begin
        left_bin  = bus.sw_min;
        right_bin = bus.sw_sec;
      end
      default: begin
        left_bin  = {2'b00, bus.hour};
        right_bin = {1'b0, bus.min};
      end
    endcase
    digits_d = {l_tens, l_ones, r_tens, r_ones};
    blank_d  = 4'b0000;
    if (phase_q && (mode_q == SET_HOUR)) blank_d = BLANK_LEFT;
    if (phase_q && (mode_q == SET_MIN))  blank_d = BLANK_RIGHT;
  end

  bin_to_bcd2 u_bcd_left (
    .bin  (left_bin),
    .tens (l_tens),
    .ones (l_ones)
  );

  bin_to_bcd2 u_bcd_right (
    .bin  (right_bin),
    .tens (r_tens),
    .ones (r_ones)
  );

  assign bus.scan_tick = scan_tick_q;
  assign bus.digits    = digits_q;
  assign bus.blank     = blank_q;
  assign bus.inc_hour  = inc_hour_q;
  assign bus.inc_min   = inc_min_q;
  assign bus.mode      = mode_q;

endmodule

// File: tb/tb_rtc_display_ctrl.sv
// Directed self-checking bench for rtc_display_ctrl with a shortened scan/blink
// time base.
module tb_rtc_display_ctrl;

  localparam int unsigned SCAN_DIV       = 4;
  localparam int unsigned BLINK_TICKS    = 2;
  localparam int unsigned TIMEOUT_BLINKS = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rtc_display_ctrl_if bus ();

  rtc_display_ctrl #(
    .SCAN_DIV       (SCAN_DIV),
    .BLINK_TICKS    (BLINK_TICKS),
    .TIMEOUT_BLINKS (TIMEOUT_BLINKS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_mode();
    bus.btn_mode = 1'b1;
    @(negedge clk);
    bus.btn_mode = 1'b0;
  endtask

  logic [6:0]  tv_min [3];
  logic [6:0]  tv_sec [3];
  logic [15:0] tv_exp [3];

  initial begin
    int first_tick;
    int ticks;
    int early_blank;
    int inc_high;
    int seen_left;
    int found;
    logic [2:0] exp_idle_mode;

    tv_min = '{7'd99, 7'd0, 7'd100};
    tv_sec = '{7'd100, 7'd59, 7'd99};
    tv_exp = '{16'h9999, 16'h0059, 16'h9999};

    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.hour     = 5'd13;
    bus.min      = 6'd7;
    bus.sec      = 6'd0;
    bus.sw_min   = 7'd0;
    bus.sw_sec   = 7'd0;

    // Reset state.
    @(negedge clk);
    check("rst_mode", 32'(bus.mode), 32'd0);
    check("rst_digits", 32'(bus.digits), 32'h0000);
    check("rst_blank", 32'(bus.blank), 32'd0);
    check("rst_scan", 32'(bus.scan_tick), 32'd0);
    check("rst_inc", 32'({bus.inc_hour, bus.inc_min}), 32'd0);
    reset = 1'b0;

    // First clock after reset: digits follow hour/min; find first scan_tick.
    first_tick = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("hm_digits", 32'(bus.digits), 32'h1307);
        check("hm_blank", 32'(bus.blank), 32'd0);
        check("hm_mode", 32'(bus.mode), 32'd0);
      end
      if (bus.scan_tick && first_tick == 0) begin
        first_tick = i;
        break;
      end
    end
    check("first_scan_tick", 32'(first_tick), 32'(SCAN_DIV));
    repeat (SCAN_DIV - 1) @(negedge clk);
    check("scan_gap_low", 32'(bus.scan_tick), 32'd0);
    @(negedge clk);
    check("scan_period", 32'(bus.scan_tick), 32'd1);

    // SHOW_MS.
    bus.sec = 6'd42;
    pulse_mode();
    check("mode_seq1", 32'(bus.mode), 32'd1);
    @(negedge clk);
    check("ms_digits", 32'(bus.digits), 32'h0742);

    // SHOW_SW with saturation.
    bus.sw_min = 7'd120;
    bus.sw_sec = 7'd5;
    pulse_mode();
    check("mode_seq2", 32'(bus.mode), 32'd2);
    @(negedge clk);
    check("sw_sat_digits", 32'(bus.digits), 32'h9905);
    for (int i = 0; i < 3; i++) begin
      bus.sw_min = tv_min[i];
      bus.sw_sec = tv_sec[i];
      @(negedge clk);
      check($sformatf("sw_vec%0d", i), 32'(bus.digits), 32'(tv_exp[i]));
    end

    // SET_HOUR shows hour:min.
    pulse_mode();
    check("mode_seq3", 32'(bus.mode), 32'd3);
    @(negedge clk);
    check("set_hour_digits", 32'(bus.digits), 32'h1307);

    // Simultaneous mode+inc: mode advances, inc dropped.
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    @(negedge clk);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    check("both_mode", 32'(bus.mode), 32'd4);
    check("both_no_inc_hour", 32'(bus.inc_hour), 32'd0);
    @(negedge clk);
    check("both_no_inc_late", 32'({bus.inc_hour, bus.inc_min}), 32'd0);

    // SET_MIN increment pulse and blink restart.
    bus.btn_inc = 1'b1;
    @(negedge clk);
    bus.btn_inc = 1'b0;
    check("inc_min_pulse", 32'(bus.inc_min), 32'd1);
    check("inc_hour_quiet", 32'(bus.inc_hour), 32'd0);
    inc_high    = 1;
    ticks       = 0;
    early_blank = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.inc_min) inc_high++;
      if (bus.blank != 4'b0000) early_blank++;
      if (bus.scan_tick) ticks++;
      if (ticks == int'(BLINK_TICKS)) break;
    end
    check("inc_min_width", 32'(inc_high), 32'd1);
    check("blink_visible", 32'(early_blank), 32'd0);
    check("blink_tick_count", 32'(ticks), 32'(BLINK_TICKS));
    @(negedge clk);
    check("blink_right_dark", 32'(bus.blank), 32'b0011);
    check("set_min_mode_held", 32'(bus.mode), 32'd4);

    // Idle in SET_HOUR: timeout build returns to SHOW_HM, default build stays.
    for (int i = 0; i < 8 && bus.mode != 3'd3; i++) pulse_mode();
    check("enter_set_hour", 32'(bus.mode), 32'd3);
    seen_left = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.blank == 4'b1100) seen_left = 1;
    end
`ifdef RTC_DISP_SET_TIMEOUT_EN
    exp_idle_mode = 3'd0;
`else
    exp_idle_mode = 3'd3;
`endif
    check("set_hour_blink_left", 32'(seen_left), 32'd1);
    check("idle_mode", 32'(bus.mode), 32'(exp_idle_mode));

    // Asynchronous reset mid-blink in SET_MIN.
    for (int i = 0; i < 8 && bus.mode != 3'd4; i++) pulse_mode();
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.blank == 4'b0011) begin
        found = 1;
        break;
      end
    end
    check("reset_pre_blink", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_mode", 32'(bus.mode), 32'd0);
    check("arst_digits", 32'(bus.digits), 32'h0000);
    check("arst_blank", 32'(bus.blank), 32'd0);
    check("arst_scan", 32'(bus.scan_tick), 32'd0);
    check("arst_inc", 32'({bus.inc_hour, bus.inc_min}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
